pixel_write_sink: RTL and testbench
===================================

# pixel_write_sink

Receiving end of the pixel-write interface driven by the drawing blocks (vga_x, vga_y, vga_colour, vga_write). Buffers incoming pixel writes in a small FIFO, converts each (x, y) to a linear framebuffer address y*160+x, and presents them to a single-port framebuffer memory write port with a ready handshake. Also provides a full-screen clear sequencer so the top level can wipe the frame between renders.

## Interface
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2.
- SCREEN_W, 160, pixels per row.
- SCREEN_H, 120, rows.
- clock  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- vga_x  input  8  pixel column.
- vga_y  input  7  pixel row.
- vga_colour  input  18  pixel colour.
- vga_write  input  1  one-cycle strobe; sampled each rising edge.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries (combinational from count).
- clear_start  input  1  request full-screen clear.
- clear_colour  input  18  fill colour, captured with clear_start.
- clear_done  output  1  one-cycle pulse when the clear completes.
- mem_addr  output  15  framebuffer word address.
- mem_data  output  18  framebuffer write data.
- mem_we  output  1  write request; held with addr/data until accepted.
- mem_ready  input  1  memory accepts the write on any edge where mem_we && mem_ready.
- overflow  output  1  sticky: a valid pixel write was dropped because the FIFO was full.
- out_of_range  output  1  sticky: a pixel write had x >= SCREEN_W or y >= SCREEN_H.

## Operation
- Push: on an edge with vga_write=1, coordinates are checked. Out of range -> dropped, out_of_range set. In range -> pushed if the FIFO is not full, or if it is full and a pop occurs on the same edge; otherwise dropped and overflow set.
- Address: mem_addr = vga_y*SCREEN_W + vga_x, computed with 15-bit unsigned arithmetic at push; the FIFO stores {addr[14:0], colour[17:0]}.
- Output stage: one register set (mem_addr, mem_data, mem_we). It loads from the FIFO head (pop) when empty, or on the same edge its current write is accepted. mem_addr/mem_data stay stable while mem_we=1 and mem_ready=0.
- States: IDLE, DRAIN, CLEAR_WAIT, CLEAR, CLEAR_END.
- IDLE: FIFO empty, output stage empty. Goes to DRAIN on FIFO non-empty. Goes to CLEAR_WAIT on clear_start; clear_start has priority over a simultaneous push when choosing the next state, but the push is still accepted.
- DRAIN: pops and issues writes. Returns to IDLE when the FIFO and output stage are both empty. On clear_start, goes to CLEAR_WAIT.
- CLEAR_WAIT: keeps draining pending pixel writes. Goes to CLEAR once the FIFO and output stage are empty, so earlier pixels are overwritten by the clear.
- CLEAR: issues addresses 0..SCREEN_W*SCREEN_H-1 (0..19199) in order, with the colour captured at clear_start and one accepted write per ready cycle. No FIFO pops occur in CLEAR. Pushes continue and are held in the FIFO; a full FIFO drops pushes and sets overflow. Goes to CLEAR_END when the write to address 19199 is accepted.
- CLEAR_END: clear_done=1 for one cycle, then IDLE, or DRAIN if the FIFO is non-empty.
- clear_start in CLEAR_WAIT, CLEAR or CLEAR_END is ignored.
- clear_start in IDLE or DRAIN also clears the overflow and out_of_range flags. A drop on the same edge wins and sets its flag.
- Reset: async resetn=0 forces IDLE, FIFO empty, and all outputs 0 (mem_we, mem_addr, mem_data, clear_done, overflow, out_of_range; fifo_full=0). Reset mid-clear aborts the clear and produces no clear_done.

## Timing
- Latency: vga_write sampled at edge E with the FIFO and output stage empty -> FIFO entry at E; mem_we=1 with the correct address/data after edge E+1.
- Throughput: with mem_ready held at 1, one pixel write is accepted per cycle, sustained. Clear takes 19200 cycles of ready, plus 1 entry cycle and 1 done cycle.
- mem_ready low stalls the output stage. The FIFO absorbs up to FIFO_DEPTH further pushes.
- Flags are set on the edge after the dropping strobe.
- clear_done is asserted exactly one cycle after the final accepted clear write.

## Test plan
- Single pixel: x=5, y=3, colour=18'h3FFFF, mem_ready=1 -> exactly one write with mem_addr=485 and mem_data=18'h3FFFF, mem_we high 2 edges after the strobe.
- Backpressure/overflow: mem_ready=0; 6 strobes on consecutive cycles -> first goes to the output stage, next 4 fill the FIFO, the 6th is dropped, overflow=1, fifo_full=1. Raise mem_ready -> 5 writes in push order.
- Range: (x=159, y=119) -> addr 19199 written. (x=160, y=0) and (x=0, y=120) -> no write, out_of_range=1.
- Clear ordering: 2 pixels pushed, then clear_start with clear_colour=0 -> both pixel writes precede address 0. 19200 sequential writes follow, then one clear_done pulse. A pixel pushed during the clear is written after clear_done.
- Stall mid-clear: toggle mem_ready randomly -> every address 0..19199 is written exactly once, in order, with stable addr/data while stalled.
- Reset mid-clear: resetn low at address ~1000 -> all outputs 0 immediately, no clear_done; after release, a new pixel write works normally.

Source files
------------

// File: rtl/pixel_write_sink.sv
// Pixel-write sink: buffers (x, y, colour) strobes in a small FIFO, linearises to
// framebuffer addresses, drives a ready-handshaked write port, and sequences full-screen clears.
module pixel_write_sink #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [17:0] vga_colour,
  input  logic        vga_write,
  output logic        fifo_full,
  input  logic        clear_start,
  input  logic [17:0] clear_colour,
  output logic        clear_done,
  output logic [14:0] mem_addr,
  output logic [17:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        overflow,
  output logic        out_of_range
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned COL_W  = 18;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_CLEAR_WAIT, S_CLEAR, S_CLEAR_END
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  colour;
  } pix_t;

  state_e             state_q, state_d;
  pix_t               fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COL_W-1:0]   data_q, data_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               oor_q, oor_d;
  logic [ADDR_W-1:0]  clr_next_q, clr_next_d;
  logic [COL_W-1:0]   clr_col_q, clr_col_d;

  logic in_range, fifo_empty, accept, pop, push, clear_req, drain_state, stage_empty;
  pix_t push_pix, head;

  assign in_range    = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign accept      = we_q && mem_ready;
  assign stage_empty = fifo_empty && !we_q;
  assign drain_state = (state_q == S_IDLE) || (state_q == S_DRAIN) || (state_q == S_CLEAR_WAIT);
  // Head moves to the output stage when the stage is free or being accepted this edge.
  assign pop         = drain_state && !fifo_empty && (!we_q || mem_ready);
  assign push        = vga_write && in_range && (!fifo_full || pop);
  assign clear_req   = clear_start && ((state_q == S_IDLE) || (state_q == S_DRAIN));
  assign push_pix.addr   = ADDR_W'(vga_y) * ADDR_W'(SCREEN_W) + ADDR_W'(vga_x);
  assign push_pix.colour = vga_colour;
  assign head        = fifo_q[rd_ptr_q];

  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_we       = we_q;
  assign clear_done   = done_q;
  assign overflow     = ovf_q;
  assign out_of_range = oor_q;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clear_start)      state_d = S_CLEAR_WAIT;
        else if (!fifo_empty) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (clear_start)      state_d = S_CLEAR_WAIT;
        else if (stage_empty) state_d = S_IDLE;
      end
      S_CLEAR_WAIT: if (stage_empty) state_d = S_CLEAR;
      S_CLEAR:      if (accept && (addr_q == LAST_ADDR)) state_d = S_CLEAR_END;
      S_CLEAR_END:  state_d = fifo_empty ? S_IDLE : S_DRAIN;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output stage, clear sequencer and flag logic
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    oor_d      = oor_q;
    clr_next_d = clr_next_q;
    clr_col_d  = clr_col_q;

    if (clear_req) begin
      ovf_d      = 1'b0;
      oor_d      = 1'b0;
      clr_col_d  = clear_colour;
      clr_next_d = '0;
    end
    if (vga_write && !in_range)         oor_d = 1'b1;
    if (vga_write && in_range && !push) ovf_d = 1'b1;

    if (accept) we_d = 1'b0;

    if (pop) begin
      addr_d = head.addr;
      data_d = head.colour;
      we_d   = 1'b1;
    end else if ((state_q == S_CLEAR) && (!we_q || accept) && (clr_next_q <= LAST_ADDR)) begin
      addr_d     = clr_next_q;
      data_d     = clr_col_q;
      we_d       = 1'b1;
      clr_next_d = clr_next_q + ADDR_W'(1);
    end

    done_d = (state_q == S_CLEAR) && accept && (addr_q == LAST_ADDR);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      oor_q      <= 1'b0;
      clr_next_q <= '0;
      clr_col_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      oor_q      <= oor_d;
      clr_next_q <= clr_next_d;
      clr_col_q  <= clr_col_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= push_pix;
  end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed self-checking bench for pixel_write_sink.
module tb_pixel_write_sink;

  logic        clock;
  logic        resetn;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        fifo_full;
  logic        clear_start;
  logic [17:0] clear_colour;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        mem_ready;
  logic        overflow;
  logic        out_of_range;

  int checks = 0;
  int errors = 0;

  pixel_write_sink dut (
    .clock(clock), .resetn(resetn),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
    .fifo_full(fifo_full),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .overflow(overflow), .out_of_range(out_of_range)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    resetn = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_write = 1'b0;
    clear_start = 1'b0; clear_colour = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_we, mem_addr, mem_data, clear_done, overflow, out_of_range, fifo_full} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h done=%b ovf=%b oor=%b full=%b, required all 0",
               mem_we, mem_addr, mem_data, clear_done, overflow, out_of_range, fifo_full);
    end
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if ({mem_we, clear_done, overflow, out_of_range, fifo_full} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: we=%b done=%b ovf=%b oor=%b full=%b, required 0",
               mem_we, clear_done, overflow, out_of_range, fifo_full);
    end
  endtask

  task automatic test_single_pixel();
    int nwr;
    mem_ready = 1'b1;
    vga_x = 8'd5; vga_y = 7'd3; vga_colour = 18'h3FFFF; vga_write = 1'b1;
    @(negedge clock);
    vga_write = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: mem_we=%b one edge after strobe, required 0", mem_we);
    end
    @(negedge clock);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd485 || mem_data !== 18'h3FFFF) begin
      errors++;
      $display("FAIL single_write: we=%b addr=%0d data=%h, required we=1 addr=485 data=3ffff",
               mem_we, mem_addr, mem_data);
    end
    nwr = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_we && mem_ready) nwr++;
      @(negedge clock);
    end
    checks++;
    if (nwr !== 1) begin
      errors++;
      $display("FAIL single_count: %0d writes accepted, required 1", nwr);
    end
  endtask

  task automatic test_backpressure();
    logic [14:0] got_a [8];
    logic [17:0] got_d [8];
    int n, bad;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vga_x = 8'(i * 10 + 1); vga_y = 7'(i); vga_colour = 18'(i + 100); vga_write = 1'b1;
      @(negedge clock);
    end
    vga_write = 1'b0;
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL bp_flags: overflow=%b fifo_full=%b, required 1 1", overflow, fifo_full);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd1 || mem_data !== 18'd100) begin
      errors++;
      $display("FAIL bp_stall_hold: we=%b addr=%0d data=%0d, required 1 1 100", mem_we, mem_addr, mem_data);
    end
    mem_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_we && mem_ready && n < 8) begin
        got_a[n] = mem_addr; got_d[n] = mem_data; n++;
      end
      @(negedge clock);
    end
    bad = 0;
    for (int i = 0; i < 5 && i < n; i++)
      if (got_a[i] !== 15'(i * 170 + 1) || got_d[i] !== 18'(i + 100)) bad++;
    checks++;
    if (n !== 5 || bad !== 0) begin
      errors++;
      $display("FAIL bp_drain: %0d writes with %0d wrong, required 5 writes in push order", n, bad);
    end
    checks++;
    if (fifo_full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_drain: fifo_full=%b overflow=%b, required 0 1", fifo_full, overflow);
    end
  endtask

  task automatic test_range();
    int nwr;
    logic [14:0] a;
    logic [17:0] d;
    mem_ready = 1'b1;
    vga_x = 8'd159; vga_y = 7'd119; vga_colour = 18'h15555; vga_write = 1'b1;
    @(negedge clock);
    vga_write = 1'b0;
    nwr = 0; a = '0; d = '0;
    for (int c = 0; c < 5; c++) begin
      if (mem_we && mem_ready) begin nwr++; a = mem_addr; d = mem_data; end
      @(negedge clock);
    end
    checks++;
    if (nwr !== 1 || a !== 15'd19199 || d !== 18'h15555 || out_of_range !== 1'b0) begin
      errors++;
      $display("FAIL range_corner: %0d writes addr=%0d data=%h oor=%b, required 1 write 19199 15555 oor 0",
               nwr, a, d, out_of_range);
    end
    vga_x = 8'd160; vga_y = 7'd0; vga_write = 1'b1;
    @(negedge clock);
    vga_write = 1'b0;
    checks++;
    if (out_of_range !== 1'b1) begin
      errors++;
      $display("FAIL range_x_flag: out_of_range=%b, required 1", out_of_range);
    end
    vga_x = 8'd0; vga_y = 7'd120; vga_write = 1'b1;
    @(negedge clock);
    vga_write = 1'b0;
    nwr = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_we) nwr++;
      @(negedge clock);
    end
    checks++;
    if (nwr !== 0 || out_of_range !== 1'b1) begin
      errors++;
      $display("FAIL range_drop: %0d write cycles oor=%b, required 0 and 1", nwr, out_of_range);
    end
  endtask

  task automatic test_clear_order();
    int nacc, bad, done_cnt, done_cyc, last_cyc, c_cyc;
    logic a_ok, b_ok, c_ok, c_pushed, flags_ok;
    nacc = 0; bad = 0; done_cnt = 0; done_cyc = -1; last_cyc = -2; c_cyc = -1;
    a_ok = 1'b0; b_ok = 1'b0; c_ok = 1'b0; c_pushed = 1'b0; flags_ok = 1'b0;
    mem_ready = 1'b1;
    vga_x = 8'd7; vga_y = 7'd1; vga_colour = 18'h0AAAA; vga_write = 1'b1;
    @(negedge clock);
    vga_x = 8'd20; vga_y = 7'd50; vga_colour = 18'h05555;
    @(negedge clock);
    vga_write = 1'b0;
    clear_start = 1'b1; clear_colour = 18'h0;
    for (int cyc = 0; cyc < 19400 && c_cyc < 0; cyc++) begin
      if (cyc == 1) flags_ok = (overflow === 1'b0) && (out_of_range === 1'b0);
      if (mem_we && mem_ready) begin
        if (nacc == 0)          a_ok = (mem_addr === 15'd167) && (mem_data === 18'h0AAAA);
        else if (nacc == 1)     b_ok = (mem_addr === 15'd8020) && (mem_data === 18'h05555);
        else if (nacc < 19202) begin
          if (mem_addr !== 15'(nacc - 2) || mem_data !== 18'h0) bad++;
          if (nacc == 19201) last_cyc = cyc;
        end else begin
          c_ok = (mem_addr === 15'd643) && (mem_data === 18'h1F0F0);
          c_cyc = cyc;
        end
        nacc++;
      end
      if (clear_done) begin done_cnt++; done_cyc = cyc; end
      clear_start = (cyc == 0);
      vga_write = 1'b0;
      if (nacc == 1000 && !c_pushed) begin
        vga_x = 8'd3; vga_y = 7'd4; vga_colour = 18'h1F0F0; vga_write = 1'b1; c_pushed = 1'b1;
      end
      @(negedge clock);
    end
    vga_write = 1'b0; clear_start = 1'b0;
    checks++;
    if (!flags_ok) begin
      errors++;
      $display("FAIL clear_flags: overflow/out_of_range not cleared by clear_start, required 0 0");
    end
    checks++;
    if (!a_ok || !b_ok) begin
      errors++;
      $display("FAIL clear_pixels_first: first=%b second=%b, required both pixel writes before address 0", a_ok, b_ok);
    end
    checks++;
    if (bad !== 0 || nacc < 19202) begin
      errors++;
      $display("FAIL clear_sequence: %0d wrong of %0d accepted, required 0 wrong and 19202+ accepted", bad, nacc);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
      errors++;
      $display("FAIL clear_done_pulse: %0d pulses at cycle %0d, last clear write cycle %0d, required 1 pulse one cycle later",
               done_cnt, done_cyc, last_cyc);
    end
    checks++;
    if (!c_ok || c_cyc <= done_cyc) begin
      errors++;
      $display("FAIL clear_held_pixel: ok=%b at cycle %0d (done at %0d), required addr 643 after clear_done",
               c_ok, c_cyc, done_cyc);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_stall_clear();
    int exp_next, bad, unstable, done_cnt;
    logic prev_stall;
    logic [14:0] prev_a;
    logic [17:0] prev_d;
    exp_next = 0; bad = 0; unstable = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    clear_start = 1'b1; clear_colour = 18'h2A5A5;
    for (int cyc = 0; cyc < 40000 && done_cnt == 0; cyc++) begin
      if (prev_stall && (mem_we !== 1'b1 || mem_addr !== prev_a || mem_data !== prev_d)) unstable++;
      clear_start = (cyc == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (mem_we && mem_ready) begin
        if (mem_addr !== 15'(exp_next) || mem_data !== 18'h2A5A5) bad++;
        exp_next++;
      end
      if (clear_done) done_cnt++;
      prev_stall = mem_we && !mem_ready;
      prev_a = mem_addr; prev_d = mem_data;
      @(negedge clock);
    end
    clear_start = 1'b0; mem_ready = 1'b1;
    checks++;
    if (bad !== 0 || exp_next !== 19200) begin
      errors++;
      $display("FAIL stall_clear_order: %0d writes, %0d wrong, required 19200 in order", exp_next, bad);
    end
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL stall_clear_stable: %0d unstable stalled cycles, required 0", unstable);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_clear_done: %0d clear_done pulses, required 1", done_cnt);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_clear();
    int waited, ndone, nwe, nwr;
    logic [14:0] a;
    logic [17:0] d;
    mem_ready = 1'b1;
    clear_start = 1'b1; clear_colour = 18'h3C3C3;
    @(negedge clock);
    clear_start = 1'b0;
    waited = 0;
    while (mem_addr < 15'd1000 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (waited >= 2000) begin
      errors++;
      $display("FAIL rst_mid_reach: mem_addr=%0d after %0d cycles, required >= 1000", mem_addr, waited);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_data, clear_done, overflow, out_of_range, fifo_full} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: we=%b addr=%0d data=%h done=%b, required all 0",
               mem_we, mem_addr, mem_data, clear_done);
    end
    @(negedge clock);
    resetn = 1'b1;
    ndone = 0; nwe = 0;
    for (int c = 0; c < 30; c++) begin
      if (clear_done) ndone++;
      if (mem_we) nwe++;
      @(negedge clock);
    end
    checks++;
    if (ndone !== 0 || nwe !== 0) begin
      errors++;
      $display("FAIL rst_mid_abort: %0d done pulses, %0d write cycles, required 0 0", ndone, nwe);
    end
    vga_x = 8'd10; vga_y = 7'd2; vga_colour = 18'h12345; vga_write = 1'b1;
    @(negedge clock);
    vga_write = 1'b0;
    nwr = 0; a = '0; d = '0;
    for (int c = 0; c < 8; c++) begin
      if (mem_we && mem_ready) begin nwr++; a = mem_addr; d = mem_data; end
      @(negedge clock);
    end
    checks++;
    if (nwr !== 1 || a !== 15'd330 || d !== 18'h12345) begin
      errors++;
      $display("FAIL rst_mid_recover: %0d writes addr=%0d data=%h, required 1 write 330 12345", nwr, a, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_range();
    test_clear_order();
    test_stall_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
